// File: rtl/pool_addr_pkg.sv
// Shared types and helpers for the pooling-window address generator.
// State encoding and a width function that never returns zero.
package pool_addr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int clog2f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_window_addr_gen_lat_pipe.sv
// Valid-plus-tag delay line modelling the memory read latency.
// DEPTH of zero degenerates to a wire-through.
module lat_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_tag,
    output logic         out_valid,
    output logic [W-1:0] out_tag
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk;
        assign unused_clk = clk ^ reset;
        assign out_valid  = in_valid;
        assign out_tag    = in_tag;
    end else begin : g_pipe
        logic [DEPTH-1:0]        v_q;
        logic [DEPTH-1:0][W-1:0] t_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= '0;
                t_q <= '0;
            end else begin
                v_q[0] <= in_valid;
                t_q[0] <= in_tag;
                for (int s = 1; s < DEPTH; s++) begin
                    v_q[s] <= v_q[s-1];
                    t_q[s] <= t_q[s-1];
                end
            end
        end

        assign out_valid = v_q[DEPTH-1];
        assign out_tag   = t_q[DEPTH-1];
    end

endmodule

// File: rtl/pool_window_addr_gen.sv
// Walks a multi-channel feature map in non-overlapping KxK windows,
// presenting all K*K read addresses of one window per handshake.
module pool_window_addr_gen
    import pool_addr_pkg::*;
#(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int K        = 2,
    parameter int CH       = 1,
    parameter int READ_LAT = 1,
    localparam int AW  = clog2f(CH * IMG_W * IMG_H),
    localparam int GC  = IMG_W / K,
    localparam int GR  = IMG_H / K,
    localparam int CHW = clog2f(CH),
    localparam int RW  = clog2f(GR),
    localparam int LW  = clog2f(GC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              win_ready,
    output logic              win_valid,
    output logic [K*K*AW-1:0] addr,
    output logic [CHW-1:0]    win_ch,
    output logic [RW-1:0]     win_row,
    output logic [LW-1:0]     win_col,
    output logic              rd_valid,
    output logic [CHW-1:0]    rd_ch,
    output logic [RW-1:0]     rd_row,
    output logic [LW-1:0]     rd_col,
    output logic              busy,
    output logic              done
);

    if (IMG_W % K != 0 || IMG_H % K != 0 || K < 2 || K > 4 ||
        CH < 1 || READ_LAT < 0 || READ_LAT > 4) begin : g_bad_cfg
        $error("pool_window_addr_gen: illegal parameter set");
    end

    localparam int TW = CHW + RW + LW;
    localparam logic [CHW-1:0] CH_LAST  = CHW'(CH - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(GR - 1);
    localparam logic [LW-1:0]  COL_LAST = LW'(GC - 1);
    localparam logic [AW-1:0]  COL_STEP = AW'(K);
    localparam logic [AW-1:0]  ROW_STEP = AW'((K - 1) * IMG_W + K);
    localparam logic [2:0]     DRAIN_INIT = 3'(READ_LAT > 0 ? READ_LAT - 1 : 0);

    state_t          state_q, state_d;
    logic [CHW-1:0]  ch_q;
    logic [RW-1:0]   row_q;
    logic [LW-1:0]   col_q;
    logic [AW-1:0]   base_q;
    logic [2:0]      drain_q;
    logic            load;
    logic            accept;
    logic            last_win;
    logic [TW-1:0]   acc_tag;
    logic [TW-1:0]   rd_tag;

    assign win_valid = (state_q == RUN);
    assign accept    = win_valid && win_ready;
    assign last_win  = (ch_q == CH_LAST) && (row_q == ROW_LAST) &&
                       (col_q == COL_LAST);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (accept && last_win) begin
                    state_d = (READ_LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (drain_q == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Row wrap steps the base past the K-1 rows already covered.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            ch_q   <= '0;
            row_q  <= '0;
            col_q  <= '0;
            base_q <= '0;
        end else if (accept && !last_win) begin
            if (col_q == COL_LAST) begin
                col_q  <= '0;
                base_q <= base_q + ROW_STEP;
                if (row_q == ROW_LAST) begin
                    row_q <= '0;
                    ch_q  <= ch_q + CHW'(1);
                end else begin
                    row_q <= row_q + RW'(1);
                end
            end else begin
                col_q  <= col_q + LW'(1);
                base_q <= base_q + COL_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_q <= '0;
        end else if (state_q == RUN) begin
            drain_q <= DRAIN_INIT;
        end else if (state_q == DRAIN && drain_q != 3'd0) begin
            drain_q <= drain_q - 3'd1;
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            localparam logic [AW-1:0] OFF = AW'(i * IMG_W + j);
            assign addr[(i*K+j)*AW +: AW] = win_valid ? base_q + OFF : '0;
        end
    end

    assign win_ch  = win_valid ? ch_q  : '0;
    assign win_row = win_valid ? row_q : '0;
    assign win_col = win_valid ? col_q : '0;
    assign acc_tag = accept ? {ch_q, row_q, col_q} : '0;

    lat_pipe #(
        .DEPTH (READ_LAT),
        .W     (TW)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_tag    (acc_tag),
        .out_valid (rd_valid),
        .out_tag   (rd_tag)
    );

    assign {rd_ch, rd_row, rd_col} = rd_tag;

    assign busy = (state_q == RUN) || (state_q == DRAIN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_pool_window_addr_gen.sv
// Bench for pool_window_addr_gen: four configurations run side by side
// against a window-index reference model plus a table of known windows.
module tb_pool_window_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic st  [4];
    logic rdy [4];

    // u0: defaults. u1: defaults, READ_LAT=3. u2: CH=2 4x4 RL=0. u3: K=3 6x6 RL=2.
    logic [23:0] a0, a1;
    logic [19:0] a2;
    logic [53:0] a3;
    logic wv0, wv1, wv2, wv3, rv0, rv1, rv2, rv3;
    logic bz0, bz1, bz2, bz3, dn0, dn1, dn2, dn3;
    logic [0:0] wc0, wc1, wc2, wc3, rc0, rc1, rc2, rc3;
    logic [1:0] wr0, wl0, rr0, rl0, wr1, wl1, rr1, rl1;
    logic [0:0] wr2, wl2, rr2, rl2, wr3, wl3, rr3, rl3;

    pool_window_addr_gen u0 (
        .clk(clk), .reset(reset), .start(st[0]), .win_ready(rdy[0]),
        .win_valid(wv0), .addr(a0), .win_ch(wc0), .win_row(wr0),
        .win_col(wl0), .rd_valid(rv0), .rd_ch(rc0), .rd_row(rr0),
        .rd_col(rl0), .busy(bz0), .done(dn0)
    );

    pool_window_addr_gen #(.READ_LAT(3)) u1 (
        .clk(clk), .reset(reset), .start(st[1]), .win_ready(rdy[1]),
        .win_valid(wv1), .addr(a1), .win_ch(wc1), .win_row(wr1),
        .win_col(wl1), .rd_valid(rv1), .rd_ch(rc1), .rd_row(rr1),
        .rd_col(rl1), .busy(bz1), .done(dn1)
    );

    pool_window_addr_gen #(.IMG_W(4), .IMG_H(4), .CH(2), .READ_LAT(0)) u2 (
        .clk(clk), .reset(reset), .start(st[2]), .win_ready(rdy[2]),
        .win_valid(wv2), .addr(a2), .win_ch(wc2), .win_row(wr2),
        .win_col(wl2), .rd_valid(rv2), .rd_ch(rc2), .rd_row(rr2),
        .rd_col(rl2), .busy(bz2), .done(dn2)
    );

    pool_window_addr_gen #(.IMG_W(6), .IMG_H(6), .K(3), .READ_LAT(2)) u3 (
        .clk(clk), .reset(reset), .start(st[3]), .win_ready(rdy[3]),
        .win_valid(wv3), .addr(a3), .win_ch(wc3), .win_row(wr3),
        .win_col(wl3), .rd_valid(rv3), .rd_ch(rc3), .rd_row(rr3),
        .rd_col(rl3), .busy(bz3), .done(dn3)
    );

    int   o_a  [4][9];
    int   o_wc [4], o_wr [4], o_wl [4], o_rc [4], o_rr [4], o_rl [4];
    logic o_wv [4], o_rv [4], o_bz [4], o_dn [4];

    always_comb begin
        for (int u = 0; u < 4; u++) begin
            o_wv[u] = 1'b0; o_rv[u] = 1'b0; o_bz[u] = 1'b0; o_dn[u] = 1'b0;
            o_wc[u] = 0; o_wr[u] = 0; o_wl[u] = 0;
            o_rc[u] = 0; o_rr[u] = 0; o_rl[u] = 0;
            for (int i = 0; i < 9; i++) o_a[u][i] = 0;
        end
        o_wv[0] = wv0; o_rv[0] = rv0; o_bz[0] = bz0; o_dn[0] = dn0;
        o_wv[1] = wv1; o_rv[1] = rv1; o_bz[1] = bz1; o_dn[1] = dn1;
        o_wv[2] = wv2; o_rv[2] = rv2; o_bz[2] = bz2; o_dn[2] = dn2;
        o_wv[3] = wv3; o_rv[3] = rv3; o_bz[3] = bz3; o_dn[3] = dn3;
        o_wc[0] = int'(wc0); o_wr[0] = int'(wr0); o_wl[0] = int'(wl0);
        o_wc[1] = int'(wc1); o_wr[1] = int'(wr1); o_wl[1] = int'(wl1);
        o_wc[2] = int'(wc2); o_wr[2] = int'(wr2); o_wl[2] = int'(wl2);
        o_wc[3] = int'(wc3); o_wr[3] = int'(wr3); o_wl[3] = int'(wl3);
        o_rc[0] = int'(rc0); o_rr[0] = int'(rr0); o_rl[0] = int'(rl0);
        o_rc[1] = int'(rc1); o_rr[1] = int'(rr1); o_rl[1] = int'(rl1);
        o_rc[2] = int'(rc2); o_rr[2] = int'(rr2); o_rl[2] = int'(rl2);
        o_rc[3] = int'(rc3); o_rr[3] = int'(rr3); o_rl[3] = int'(rl3);
        for (int i = 0; i < 4; i++) begin
            o_a[0][i] = int'(a0[i*6 +: 6]);
            o_a[1][i] = int'(a1[i*6 +: 6]);
            o_a[2][i] = int'(a2[i*5 +: 5]);
        end
        for (int i = 0; i < 9; i++) o_a[3][i] = int'(a3[i*6 +: 6]);
    end

    function automatic int pk(input int u);
        return (u == 3) ? 3 : 2;
    endfunction
    function automatic int pw(input int u);
        return (u == 2) ? 4 : (u == 3) ? 6 : 8;
    endfunction
    function automatic int pc(input int u);
        return (u == 2) ? 2 : 1;
    endfunction
    function automatic int pl(input int u);
        return (u == 0) ? 1 : (u == 1) ? 3 : (u == 2) ? 0 : 2;
    endfunction
    function automatic int nwin(input int u);
        return pc(u) * (pw(u) / pk(u)) * (pw(u) / pk(u));
    endfunction

    // Window index n -> coordinate (0 ch, 1 row, 2 col), col fastest.
    function automatic int coord(input int u, input int n, input int which);
        int g;
        g = pw(u) / pk(u);
        if (which == 2) return n % g;
        if (which == 1) return (n / g) % g;
        return n / (g * g);
    endfunction

    function automatic int exp_addr(input int u, input int n, input int i);
        int k, w;
        k = pk(u);
        w = pw(u);
        return coord(u, n, 0) * w * w + (coord(u, n, 1) * k + i / k) * w
             + coord(u, n, 2) * k + i % k;
    endfunction

    typedef struct packed {
        int u;
        int n;
        int ch;
        int row;
        int col;
        logic [8:0][7:0] a;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(input int u, input int n, input int c,
                                input int r, input int l,
                                input int x0, input int x1, input int x2,
                                input int x3, input int x4, input int x5,
                                input int x6, input int x7, input int x8);
        vec_t v;
        v.u = u; v.n = n; v.ch = c; v.row = r; v.col = l;
        v.a[0] = 8'(x0); v.a[1] = 8'(x1); v.a[2] = 8'(x2);
        v.a[3] = 8'(x3); v.a[4] = 8'(x4); v.a[5] = 8'(x5);
        v.a[6] = 8'(x6); v.a[7] = 8'(x7); v.a[8] = 8'(x8);
        return v;
    endfunction

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mrun  [4];
    bit mdone [4];
    int nacc  [4];
    int dcnt  [4];
    int pq_due [4][16];
    int pq_idx [4][16];
    int pq_h [4];
    int pq_t [4];
    int rdcount [4];

    task automatic chk(input string nm, input int u, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s u%0d cycle %0d: got %0d want %0d", nm, u, cyc, act, exp);
        end
    endtask

    task automatic check_all();
        int  n;
        bit  ev;
        for (int u = 0; u < 4; u++) begin
            chk("win_valid", u, int'(o_wv[u]), int'(mrun[u]));
            chk("busy", u, int'(o_bz[u]), int'(mrun[u] || dcnt[u] > 0));
            chk("done", u, int'(o_dn[u]), int'(mdone[u]));
            for (int i = 0; i < 9; i++) begin
                chk("addr", u, o_a[u][i],
                    (mrun[u] && i < pk(u) * pk(u)) ? exp_addr(u, nacc[u], i) : 0);
            end
            chk("win_ch", u, o_wc[u], mrun[u] ? coord(u, nacc[u], 0) : 0);
            chk("win_row", u, o_wr[u], mrun[u] ? coord(u, nacc[u], 1) : 0);
            chk("win_col", u, o_wl[u], mrun[u] ? coord(u, nacc[u], 2) : 0);
            if (pl(u) == 0) begin
                ev = mrun[u] && rdy[u];
                n  = nacc[u];
            end else begin
                ev = (pq_h[u] != pq_t[u]) && (pq_due[u][pq_h[u]] == cyc);
                n  = pq_idx[u][pq_h[u]];
                if (ev) pq_h[u] = (pq_h[u] + 1) % 16;
            end
            chk("rd_valid", u, int'(o_rv[u]), int'(ev));
            chk("rd_ch", u, o_rc[u], ev ? coord(u, n, 0) : 0);
            chk("rd_row", u, o_rr[u], ev ? coord(u, n, 1) : 0);
            chk("rd_col", u, o_rl[u], ev ? coord(u, n, 2) : 0);
            if (o_rv[u]) rdcount[u]++;
            for (int t = 0; t < 9; t++) begin
                if (tbl[t].u == u && mrun[u] && nacc[u] == tbl[t].n) begin
                    for (int i = 0; i < pk(u) * pk(u); i++)
                        chk("tbl_addr", u, o_a[u][i], int'(tbl[t].a[i]));
                    chk("tbl_ch", u, o_wc[u], tbl[t].ch);
                    chk("tbl_row", u, o_wr[u], tbl[t].row);
                    chk("tbl_col", u, o_wl[u], tbl[t].col);
                end
            end
        end
    endtask

    task automatic step_model();
        for (int u = 0; u < 4; u++) begin
            if (reset) begin
                mrun[u] = 1'b0; mdone[u] = 1'b0;
                nacc[u] = 0; dcnt[u] = 0;
                pq_h[u] = pq_t[u];
            end else if (!mrun[u] && dcnt[u] == 0 && st[u]) begin
                mrun[u] = 1'b1; mdone[u] = 1'b0; nacc[u] = 0;
            end else if (mrun[u] && rdy[u]) begin
                if (pl(u) > 0) begin
                    pq_due[u][pq_t[u]] = cyc + pl(u);
                    pq_idx[u][pq_t[u]] = nacc[u];
                    pq_t[u] = (pq_t[u] + 1) % 16;
                end
                nacc[u]++;
                if (nacc[u] == nwin(u)) begin
                    mrun[u] = 1'b0;
                    if (pl(u) == 0) mdone[u] = 1'b1;
                    else dcnt[u] = pl(u);
                end
            end else if (dcnt[u] > 0) begin
                dcnt[u]--;
                if (dcnt[u] == 0) mdone[u] = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic tick(input bit r, input bit s, input bit rnd);
        @(negedge clk);
        reset = r;
        for (int u = 0; u < 4; u++) begin
            st[u]  = s;
            rdy[u] = (rnd && u != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #1;
        check_all();
        step_model();
    endtask

    initial begin
        tbl[0] = mk(0, 0, 0, 0, 0, 0, 1, 8, 9, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 0, 0, 1, 2, 3, 10, 11, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, 4, 0, 1, 0, 16, 17, 24, 25, 0, 0, 0, 0, 0);
        tbl[3] = mk(0, 15, 0, 3, 3, 54, 55, 62, 63, 0, 0, 0, 0, 0);
        tbl[4] = mk(1, 0, 0, 0, 0, 0, 1, 8, 9, 0, 0, 0, 0, 0);
        tbl[5] = mk(2, 4, 1, 0, 0, 16, 17, 20, 21, 0, 0, 0, 0, 0);
        tbl[6] = mk(2, 7, 1, 1, 1, 26, 27, 30, 31, 0, 0, 0, 0, 0);
        tbl[7] = mk(3, 0, 0, 0, 0, 0, 1, 2, 6, 7, 8, 12, 13, 14);
        tbl[8] = mk(3, 1, 0, 0, 1, 3, 4, 5, 9, 10, 11, 15, 16, 17);
        for (int u = 0; u < 4; u++) begin
            mrun[u] = 1'b0; mdone[u] = 1'b0; nacc[u] = 0; dcnt[u] = 0;
            pq_h[u] = 0; pq_t[u] = 0; rdcount[u] = 0;
            st[u] = 1'b0; rdy[u] = 1'b1;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);

        tick(1, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        for (int u = 0; u < 4; u++) rdcount[u] = 0;

        // First pass; start pulses while running must be ignored.
        tick(0, 1, 0);
        for (int k = 0; k < 100; k++) tick(0, k == 2 || k == 3, 1);
        for (int u = 0; u < 4; u++) chk("pass1_done", u, int'(o_dn[u]), 1);
        chk("pass1_rd_count", 1, rdcount[1], 16);
        chk("pass1_rd_count", 2, rdcount[2], 8);

        // Restart from DONE, then reset mid-run with the pipe loaded.
        tick(0, 1, 0);
        for (int k = 0; k < 6; k++) tick(0, 0, 0);
        tick(1, 0, 0);
        for (int u = 0; u < 4; u++) rdcount[u] = 0;
        for (int k = 0; k < 5; k++) tick(0, 0, 0);
        chk("no_stray_rd", 1, rdcount[1], 0);
        chk("idle_after_reset", 1, int'(o_bz[1]), 0);

        tick(0, 1, 1);
        for (int k = 0; k < 120; k++) tick(0, 0, 1);
        for (int u = 0; u < 4; u++) chk("pass2_done", u, int'(o_dn[u]), 1);
        chk("pass2_rd_count", 1, rdcount[1], 16);
        chk("pass2_rd_count", 3, rdcount[3], 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
